// File: rtl/systolic_sequencer_if.sv
// Host/array-side handshake bundle for the systolic run sequencer.
// The master drives the run controls and the sequencer owns the slave side.
interface systolic_sequencer_if #(
  parameter int N = 3,
  parameter int M = 3
);
  localparam int SEL_W = (N * M > 1) ? $clog2(N * M) : 1;

  logic             start;
  logic             abort;
  logic             c_ready;
  logic [N-1:0]     a_read_en;
  logic [M-1:0]     b_read_en;
  logic             load;
  logic [SEL_W-1:0] c_sel;
  logic             c_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, c_ready,
    input  a_read_en, b_read_en, load, c_sel, c_valid, busy, done
  );

  modport slave (
    input  start, abort, c_ready,
    output a_read_en, b_read_en, load, c_sel, c_valid, busy, done
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Run-level sequencer for an NxM output-stationary MAC array: skewed operand feed,
// pipeline flush, accumulator load, then a valid/ready drain of the N*M results.
module systolic_sequencer #(
  parameter int N = 3,
  parameter int M = 3,
  parameter int K = 3
) (
  input  logic                clk,
  input  logic                rst,
  systolic_sequencer_if.slave bus
);
  localparam int SEL_W     = (N * M > 1) ? $clog2(N * M) : 1;
  localparam int MAX_NM    = (N > M) ? N : M;
  localparam int FEED_LEN  = K + MAX_NM - 1;
  localparam int FLUSH_LEN = N + M - 1;
  localparam int MAX_LEN   = (FEED_LEN > FLUSH_LEN) ? FEED_LEN : FLUSH_LEN;
  localparam int TW        = $clog2(MAX_LEN + 1);

  localparam logic [TW-1:0]    FEED_LAST  = TW'(FEED_LEN - 1);
  localparam logic [TW-1:0]    FLUSH_LAST = TW'(FLUSH_LEN - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(N * M - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]       state;
  logic [TW-1:0]    t;
  logic [SEL_W-1:0] c_sel;
  logic [N-1:0]     a_en;
  logic [M-1:0]     b_en;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      t     <= '0;
      c_sel <= '0;
    end else if (bus.abort && state != S_IDLE) begin
      state <= S_IDLE;
      t     <= '0;
      c_sel <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state <= S_FEED;
            t     <= '0;
          end
        end
        S_FEED: begin
          if (t == FEED_LAST) begin
            state <= S_FLUSH;
            t     <= '0;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_FLUSH: begin
          if (t == FLUSH_LAST) begin
            state <= S_LOAD;
            t     <= '0;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_DRAIN;
          c_sel <= '0;
        end
        S_DRAIN: begin
          if (bus.c_ready) begin
            // The last beat parks the index at 0 instead of running past N*M-1.
            if (c_sel == SEL_LAST) begin
              state <= S_DONE;
              c_sel <= '0;
            end else begin
              c_sel <= c_sel + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: enables get an all-zero default first so no path through this block
  // leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    a_en = '0;
    b_en = '0;
    if (state == S_FEED) begin
      // Row/column i sees its K operands in the window t = i .. i+K-1 (skewed feed).
      for (int i = 0; i < N; i++) a_en[i] = (t >= TW'(i)) && (t < TW'(i + K));
      for (int j = 0; j < M; j++) b_en[j] = (t >= TW'(j)) && (t < TW'(j + K));
    end
  end

  assign bus.a_read_en = a_en;
  assign bus.b_read_en = b_en;
  assign bus.load      = (state == S_LOAD);
  assign bus.c_valid   = (state == S_DRAIN);
  assign bus.c_sel     = c_sel;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: full 3x3x3 schedule, backpressure, held start,
// abort, asynchronous reset mid-drain, and a 2x4x1 instance.
module tb_systolic_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  systolic_sequencer_if #(.N(3), .M(3)) bus0 ();
  systolic_sequencer_if #(.N(2), .M(4)) bus1 ();

  systolic_sequencer #(.N(3), .M(3), .K(3)) dut (.clk(clk), .rst(rst), .bus(bus0.slave));
  systolic_sequencer #(.N(2), .M(4), .K(1)) dut_small (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Advance one clock and land on the following falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] exp_en33(input int c);
    case (c)
      1: return 3'b001;
      2: return 3'b011;
      3: return 3'b111;
      4: return 3'b110;
      5: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    bus0.start = 0; bus0.abort = 0; bus0.c_ready = 1;
    bus1.start = 0; bus1.abort = 0; bus1.c_ready = 1;
    rst = 1;
    step();
    step();
    n_checks++;
    if ({bus0.a_read_en, bus0.b_read_en, bus0.load, bus0.c_sel, bus0.c_valid, bus0.busy, bus0.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_dut: got a=%b b=%b load=%b sel=%0d v=%b busy=%b done=%b, want all 0",
               bus0.a_read_en, bus0.b_read_en, bus0.load, bus0.c_sel, bus0.c_valid, bus0.busy, bus0.done);
    end
    n_checks++;
    if ({bus1.a_read_en, bus1.b_read_en, bus1.load, bus1.c_sel, bus1.c_valid, bus1.busy, bus1.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got a=%b b=%b busy=%b, want all 0", bus1.a_read_en, bus1.b_read_en, bus1.busy);
    end
    rst = 0;
    step();
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_busy: got %b want 0", bus0.busy);
    end
  endtask

  // Starts a 3x3x3 run from IDLE and checks every cycle; c_ready drops for `stall`
  // cycles beginning when c_sel first reaches 4 (cycle 16).
  task automatic run_dut0(input int stall, input string tag);
    int beats = 0;
    logic [2:0] ea;
    logic       ev;
    logic [3:0] es;
    bus0.start = 1;
    step();
    bus0.start = 0;
    for (int c = 1; c <= 23 + stall; c++) begin
      bus0.c_ready = !(c >= 16 && c < 16 + stall);
      ea = exp_en33(c);
      ev = (c >= 12 && c <= 20 + stall);
      es = (c < 16) ? 4'(c - 12) : (c < 16 + stall) ? 4'd4 : 4'(c - 12 - stall);
      n_checks++;
      if (bus0.a_read_en !== ea || bus0.b_read_en !== ea) begin
        n_fail++;
        $display("FAIL %s_enables c=%0d: got a=%b b=%b want %b", tag, c, bus0.a_read_en, bus0.b_read_en, ea);
      end
      n_checks++;
      if (bus0.load !== (c == 11) || bus0.done !== (c == 21 + stall) ||
          bus0.busy !== (c >= 1 && c <= 21 + stall) || bus0.c_valid !== ev) begin
        n_fail++;
        $display("FAIL %s_ctrl c=%0d: got load=%b done=%b busy=%b valid=%b", tag, c,
                 bus0.load, bus0.done, bus0.busy, bus0.c_valid);
      end
      if (ev) begin
        n_checks++;
        if (bus0.c_sel !== es) begin
          n_fail++;
          $display("FAIL %s_c_sel c=%0d: got %0d want %0d", tag, c, bus0.c_sel, es);
        end
      end
      if (bus0.c_valid && bus0.c_ready) beats++;
      step();
    end
    bus0.c_ready = 1;
    n_checks++;
    if (beats != 9) begin
      n_fail++;
      $display("FAIL %s_beats: got %0d want 9", tag, beats);
    end
  endtask

  task automatic test_schedule();
    run_dut0(0, "sched");
  endtask

  task automatic test_backpressure();
    run_dut0(3, "bp");
  endtask

  task automatic test_start_held();
    int dones = 0;
    bus0.start = 1;
    step();
    for (int c = 1; c <= 23; c++) begin
      if (bus0.done) dones++;
      if (c == 22) begin
        n_checks++;
        if (bus0.busy !== 1'b0) begin
          n_fail++;
          $display("FAIL held_idle_gap: busy got %b want 0 at c=22", bus0.busy);
        end
      end
      if (c == 23) begin
        n_checks++;
        if (bus0.busy !== 1'b1 || bus0.a_read_en !== 3'b001) begin
          n_fail++;
          $display("FAIL held_second_run: busy=%b a=%b want 1/001", bus0.busy, bus0.a_read_en);
        end
      end
      step();
    end
    bus0.start = 0;
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL held_done_count: got %0d want 1", dones);
    end
    for (int c = 0; c < 40 && bus0.busy; c++) step();
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_second_finish: busy still %b after cycle budget", bus0.busy);
    end
  endtask

  task automatic test_abort();
    int stray = 0;
    bus0.start = 1;
    bus0.abort = 1;
    step();
    bus0.start = 0;
    bus0.abort = 0;
    n_checks++;
    if (bus0.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_beats_start: busy got %b want 0", bus0.busy);
    end
    bus0.start = 1;
    step();
    bus0.start = 0;
    step();
    step();
    n_checks++;
    if (bus0.a_read_en !== 3'b111) begin
      n_fail++;
      $display("FAIL abort_pre_t2: a got %b want 111", bus0.a_read_en);
    end
    bus0.abort = 1;
    step();
    bus0.abort = 0;
    n_checks++;
    if (bus0.busy !== 1'b0 || bus0.a_read_en !== 3'b000 || bus0.b_read_en !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_to_idle: busy=%b a=%b b=%b want 0/000/000", bus0.busy, bus0.a_read_en, bus0.b_read_en);
    end
    for (int c = 0; c < 25; c++) begin
      if (bus0.load || bus0.done || bus0.busy) stray++;
      step();
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL abort_no_load_done: got %0d active cycles want 0", stray);
    end
    run_dut0(0, "post_abort");
  endtask

  task automatic test_reset_mid_drain();
    bus0.start = 1;
    step();
    bus0.start = 0;
    for (int c = 1; c < 17; c++) step();
    n_checks++;
    if (bus0.c_sel !== 4'd5 || bus0.c_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_sel: c_sel=%0d valid=%b want 5/1", bus0.c_sel, bus0.c_valid);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if ({bus0.a_read_en, bus0.b_read_en, bus0.load, bus0.c_sel, bus0.c_valid, bus0.busy, bus0.done} !== '0) begin
      n_fail++;
      $display("FAIL rst_async_clear: sel=%0d valid=%b busy=%b want all 0", bus0.c_sel, bus0.c_valid, bus0.busy);
    end
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_post_idle c=%0d: busy=%b done=%b want 0/0", c, bus0.busy, bus0.done);
      end
    end
  endtask

  task automatic test_small();
    logic [1:0] ea;
    logic [3:0] eb;
    bus1.c_ready = 1;
    bus1.start = 1;
    step();
    bus1.start = 0;
    for (int c = 1; c <= 20; c++) begin
      ea = (c == 1) ? 2'b01 : (c == 2) ? 2'b10 : 2'b00;
      eb = (c == 1) ? 4'b0001 : (c == 2) ? 4'b0010 : (c == 3) ? 4'b0100 : (c == 4) ? 4'b1000 : 4'b0000;
      n_checks++;
      if (bus1.a_read_en !== ea || bus1.b_read_en !== eb) begin
        n_fail++;
        $display("FAIL small_enables c=%0d: got a=%b b=%b want a=%b b=%b", c, bus1.a_read_en, bus1.b_read_en, ea, eb);
      end
      n_checks++;
      if (bus1.load !== (c == 10) || bus1.c_valid !== (c >= 11 && c <= 18) ||
          bus1.done !== (c == 19) || bus1.busy !== (c <= 19)) begin
        n_fail++;
        $display("FAIL small_ctrl c=%0d: load=%b valid=%b done=%b busy=%b", c,
                 bus1.load, bus1.c_valid, bus1.done, bus1.busy);
      end
      if (c >= 11 && c <= 18) begin
        n_checks++;
        if (bus1.c_sel !== 3'(c - 11)) begin
          n_fail++;
          $display("FAIL small_c_sel c=%0d: got %0d want %0d", c, bus1.c_sel, c - 11);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_schedule();
    test_backpressure();
    test_start_held();
    test_abort();
    test_reset_mid_drain();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
